// File: rtl/mid_pool_reader.sv
// Reads a completed row pair from the interleaved mid-layer bank and streams 2x2 signed max-pooled pixels.
// Optional `define POOL_RELU_EN clamps negative pooled values to zero (ReLU) with no added latency.
module mid_pool_reader #(
  parameter int DATA_W       = 21,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     pool_en,
  input  logic                     fin_rd,
  input  logic                     bram_toggle,
  input  logic signed [DATA_W-1:0] qa_0,
  input  logic signed [DATA_W-1:0] qa_1,
  input  logic signed [DATA_W-1:0] qa_2,
  input  logic signed [DATA_W-1:0] qa_3,
  input  logic signed [DATA_W-1:0] qb_0,
  input  logic signed [DATA_W-1:0] qb_1,
  input  logic signed [DATA_W-1:0] qb_2,
  input  logic signed [DATA_W-1:0] qb_3,
  input  logic signed [DATA_W-1:0] qc_0,
  input  logic signed [DATA_W-1:0] qc_1,
  input  logic signed [DATA_W-1:0] qc_2,
  input  logic signed [DATA_W-1:0] qc_3,
  output logic                     in0_rden,
  output logic                     in1_rden,
  output logic                     in2_rden,
  output logic                     in3_rden,
  output logic [10:0]              rd_addr,
  output logic signed [DATA_W-1:0] pool_a,
  output logic signed [DATA_W-1:0] pool_b,
  output logic signed [DATA_W-1:0] pool_c,
  output logic                     pool_valid,
  output logic                     row_last,
  output logic                     frame_last,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ROWS = (IMAGE_HEIGHT / 2 < 1) ? 1 : IMAGE_HEIGHT / 2;
  localparam int RCW  = $clog2(ROWS + 1);
  localparam logic [10:0]    LAST_ADDR = 11'(IMAGE_WIDTH - 1);
  localparam logic [10:0]    LAST_ODD  = 11'((IMAGE_WIDTH / 2) * 2 - 1);
  localparam logic [RCW-1:0] LAST_ROW  = RCW'(ROWS - 1);

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] x,
                                                    input logic signed [DATA_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] x);
`ifdef POOL_RELU_EN
    return x[DATA_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  state_t state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic drain_q, drain_d;
  logic sel_q, sel_d;
  logic overrun_q, overrun_d;
  logic dvalid_q, dvalid_d;
  logic [10:0] dcol_q, dcol_d;
  logic signed [DATA_W-1:0] v0_q[3], v0_d[3];
  logic signed [DATA_W-1:0] pool_q[3], pool_d[3];
  logic pool_valid_q, pool_valid_d;
  logic row_last_q, row_last_d;
  logic frame_last_q, frame_last_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic signed [DATA_W-1:0] top_s[3], bot_s[3], col_max[3];
  logic fire, is_last_col;

  // Control: pool_en low wins over every transition and parks the FSM in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    sel_d     = sel_q;
    overrun_d = overrun_q | (fin_rd & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (fin_rd && pool_en) begin
          state_d = READ;
          sel_d   = bram_toggle;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 11'd1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!pool_en) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end

  // Data path: bank outputs for the address issued last cycle are valid when dvalid_q is set.
  always_comb begin
    top_s[0] = sel_q ? qa_0 : qa_2;
    bot_s[0] = sel_q ? qa_1 : qa_3;
    top_s[1] = sel_q ? qb_0 : qb_2;
    bot_s[1] = sel_q ? qb_1 : qb_3;
    top_s[2] = sel_q ? qc_0 : qc_2;
    bot_s[2] = sel_q ? qc_1 : qc_3;
    for (int i = 0; i < 3; i++) col_max[i] = smax(top_s[i], bot_s[i]);
  end

  always_comb begin
    dvalid_d     = (state_q == READ) && pool_en;
    dcol_d       = addr_q;
    v0_d         = v0_q;
    pool_d       = pool_q;
    pool_valid_d = 1'b0;
    row_last_d   = 1'b0;
    frame_last_d = 1'b0;
    row_cnt_d    = row_cnt_q;
    fire         = dvalid_q && dcol_q[0] && pool_en;
    is_last_col  = (dcol_q == LAST_ODD);
    if (dvalid_q && !dcol_q[0]) v0_d = col_max;
    if (fire) begin
      for (int i = 0; i < 3; i++) pool_d[i] = act(smax(v0_q[i], col_max[i]));
      pool_valid_d = 1'b1;
      row_last_d   = is_last_col;
      if (is_last_col) begin
        if (row_cnt_q == LAST_ROW) begin
          frame_last_d = 1'b1;
          row_cnt_d    = '0;
        end else begin
          row_cnt_d = row_cnt_q + RCW'(1);
        end
      end
    end
    if (!pool_en) row_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      drain_q      <= 1'b0;
      sel_q        <= 1'b0;
      overrun_q    <= 1'b0;
      dvalid_q     <= 1'b0;
      dcol_q       <= '0;
      pool_valid_q <= 1'b0;
      row_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      row_cnt_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        v0_q[i]   <= '0;
        pool_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
      sel_q        <= sel_d;
      overrun_q    <= overrun_d;
      dvalid_q     <= dvalid_d;
      dcol_q       <= dcol_d;
      pool_valid_q <= pool_valid_d;
      row_last_q   <= row_last_d;
      frame_last_q <= frame_last_d;
      row_cnt_q    <= row_cnt_d;
      v0_q         <= v0_d;
      pool_q       <= pool_d;
    end
  end

  assign in0_rden   = (state_q == READ) &  sel_q;
  assign in1_rden   = (state_q == READ) &  sel_q;
  assign in2_rden   = (state_q == READ) & ~sel_q;
  assign in3_rden   = (state_q == READ) & ~sel_q;
  assign rd_addr    = addr_q;
  assign pool_a     = pool_q[0];
  assign pool_b     = pool_q[1];
  assign pool_c     = pool_q[2];
  assign pool_valid = pool_valid_q;
  assign row_last   = row_last_q;
  assign frame_last = frame_last_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mid_pool_reader.sv
// Bench for mid_pool_reader: bank memory model, row-level behavioural reference, per-cycle compare.
module tb_mid_pool_reader;
  localparam int DW  = 21;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int BIG = 32'h3fffffff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic RESET = 1'b1;
  logic pool_en = 1'b1;
  logic fin_rd = 1'b0;
  logic bram_toggle = 1'b0;
  logic signed [DW-1:0] q_r[4][3];
  logic in0_rden, in1_rden, in2_rden, in3_rden;
  logic [10:0] rd_addr;
  logic signed [DW-1:0] pool_a, pool_b, pool_c;
  logic pool_valid, row_last, frame_last, busy, overrun;
  logic [1:0] dbg_state;

  mid_pool_reader #(.DATA_W(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .RESET(RESET), .pool_en(pool_en), .fin_rd(fin_rd), .bram_toggle(bram_toggle),
    .qa_0(q_r[0][0]), .qa_1(q_r[1][0]), .qa_2(q_r[2][0]), .qa_3(q_r[3][0]),
    .qb_0(q_r[0][1]), .qb_1(q_r[1][1]), .qb_2(q_r[2][1]), .qb_3(q_r[3][1]),
    .qc_0(q_r[0][2]), .qc_1(q_r[1][2]), .qc_2(q_r[2][2]), .qc_3(q_r[3][2]),
    .in0_rden(in0_rden), .in1_rden(in1_rden), .in2_rden(in2_rden), .in3_rden(in3_rden),
    .rd_addr(rd_addr), .pool_a(pool_a), .pool_b(pool_b), .pool_c(pool_c),
    .pool_valid(pool_valid), .row_last(row_last), .frame_last(frame_last),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // Bank memories with one-cycle read latency.
  logic signed [DW-1:0] mem[4][3][W];
  logic [3:0] rden_v;
  assign rden_v = {in3_rden, in2_rden, in1_rden, in0_rden};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (rden_v[b] && rd_addr < 11'(W))
        for (int c = 0; c < 3; c++) q_r[b][c] <= mem[b][c][rd_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    logic [DW-1:0] a, b, c;
    bit rl;
  } exp_t;
  exp_t exp_q[$];
  int start = -1, abort = BIG, ovr_from = BIG, rows_done = 0;
  bit sel = 1'b0;
  logic [DW-1:0] held[3] = '{default: '0};
  int n_cmp = 0, n_err = 0, obs_valid = 0, obs_rl = 0, obs_fl = 0;

  function automatic bit m_busy(int n);
    return start >= 0 && n >= start + 1 && n <= start + W + 2 && n <= abort;
  endfunction

  function automatic logic [DW-1:0] model_px(int top, int bot, int ch, int k);
    logic signed [DW-1:0] m;
    m = mem[top][ch][2*k];
    if (mem[top][ch][2*k+1] > m) m = mem[top][ch][2*k+1];
    if (mem[bot][ch][2*k] > m)   m = mem[bot][ch][2*k];
    if (mem[bot][ch][2*k+1] > m) m = mem[bot][ch][2*k+1];
`ifdef POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit v, rl, fl, rd;
    exp_t e;
    v = 0; rl = 0; fl = 0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      v = 1; rl = e.rl;
      held[0] = e.a; held[1] = e.b; held[2] = e.c;
      if (rl) begin
        rows_done++;
        if (rows_done == H / 2) begin fl = 1; rows_done = 0; end
      end
    end
    rd = start >= 0 && cyc >= start + 1 && cyc <= start + W && cyc <= abort;
    chk("pool_valid", 32'(pool_valid), 32'(v));
    chk("row_last",   32'(row_last),   32'(rl));
    chk("frame_last", 32'(frame_last), 32'(fl));
    chk("pool_a", 32'(unsigned'(pool_a)), 32'(held[0]));
    chk("pool_b", 32'(unsigned'(pool_b)), 32'(held[1]));
    chk("pool_c", 32'(unsigned'(pool_c)), 32'(held[2]));
    chk("rden",    32'(rden_v), rd ? (sel ? 32'h3 : 32'hc) : 32'h0);
    chk("rd_addr", 32'(rd_addr), rd ? 32'(cyc - start - 1) : 32'h0);
    chk("busy",    32'(busy), 32'(m_busy(cyc)));
    chk("overrun", 32'(overrun), 32'(cyc >= ovr_from));
    if (pool_valid) obs_valid++;
    if (row_last) obs_rl++;
    if (frame_last) obs_fl++;
    if (!pool_en) rows_done = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fin_pulse(input bit tog);
    exp_t e;
    int top, bot;
    if (pool_en && !m_busy(cyc)) begin
      start = cyc; abort = BIG; sel = tog;
      top = tog ? 0 : 2; bot = tog ? 1 : 3;
      for (int k = 0; k < W / 2; k++) begin
        e.cyc = cyc + 4 + 2 * k;
        e.a = model_px(top, bot, 0, k);
        e.b = model_px(top, bot, 1, k);
        e.c = model_px(top, bot, 2, k);
        e.rl = (k == W / 2 - 1);
        exp_q.push_back(e);
      end
    end else if (m_busy(cyc) && ovr_from > cyc + 1) begin
      ovr_from = cyc + 1;
    end
    fin_rd = 1'b1; bram_toggle = tog;
    wait_cycles(1);
    fin_rd = 1'b0;
  endtask

  task automatic drop_en();
    abort = cyc;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc > cyc) exp_q.delete(i);
    pool_en = 1'b0;
    wait_cycles(1);
    pool_en = 1'b1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    start = -1; abort = BIG; ovr_from = BIG; rows_done = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) held[i] = '0;
    wait_cycles(n);
    RESET = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int c = 0; c < 3; c++)
      for (int n = 0; n < W; n++) begin
        mem[0][c][n] = DW'(n);
        mem[1][c][n] = -DW'(n);
      end
  endtask

  task automatic fill_const(input logic signed [DW-1:0] v);
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 3; c++)
        for (int n = 0; n < W; n++) mem[b][c][n] = v;
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 3; c++)
        for (int n = 0; n < W; n++) mem[b][c][n] = DW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 3; c++) q_r[b][c] = '0;
    fill_const('0);
    #1;
    do_reset(3);
    chk("rst_busy", 32'(busy), 32'h0);
    wait_cycles(2);

    // Ramp rows on banks 0/1: pixels 1,3,...,27.
    fill_ramp();
    fin_pulse(1'b1);
    chk("t1_rden0", 32'(in0_rden), 32'h1);
    wait_cycles(29);
    chk("t1_last_px", 32'(unsigned'(pool_a)), 32'd27);
    chk("t1_row_last", 32'(row_last), 32'h1);
    wait_cycles(5);

    // Banks 2/3: one hot column at 7.
    for (int c = 0; c < 3; c++)
      for (int n = 0; n < W; n++) begin
        mem[2][c][n] = -21'sd5;
        mem[3][c][n] = (n == 7) ? 21'sd100 : -21'sd9;
      end
    fin_pulse(1'b0);
    wait_cycles(9);
    chk("t2_px3", 32'(unsigned'(pool_a)), 32'd100);
    wait_cycles(2);
    chk("t2_px4", 32'(unsigned'(pool_b)), 32'h1ffffb);
    wait_cycles(25);

    // Second fin_rd during READ.
    fin_pulse(1'b1);
    wait_cycles(9);
    fin_pulse(1'b1);
    wait_cycles(30);
    chk("t4_overrun", 32'(overrun), 32'h1);

    // pool_en dropped mid-row, then a clean row.
    fin_pulse(1'b1);
    wait_cycles(11);
    drop_en();
    wait_cycles(1);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_addr", 32'(rd_addr), 32'h0);
    wait_cycles(5);
    fin_pulse(1'b0);
    wait_cycles(35);

    do_reset(2);
    chk("rst_overrun", 32'(overrun), 32'h0);
    wait_cycles(2);

    // Full frame of 14 row pairs.
    fill_rand();
    obs_valid = 0; obs_rl = 0; obs_fl = 0;
    for (int r = 0; r < H / 2; r++) begin
      fin_pulse(r[0]);
      wait_cycles(59);
    end
    chk("t3_valids", 32'(obs_valid), 32'd196);
    chk("t3_rowlast", 32'(obs_rl), 32'd14);
    chk("t3_framelast", 32'(obs_fl), 32'd1);

    // Randomised rows with occasional overlap and aborts.
    for (int it = 0; it < 20; it++) begin
      int r;
      fill_rand();
      fin_pulse(1'($urandom_range(0, 1)));
      r = $urandom_range(0, 5);
      if (r == 0) begin
        wait_cycles($urandom_range(2, 25));
        fin_pulse(1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        wait_cycles($urandom_range(2, 30));
        drop_en();
      end
      wait_cycles(35 + $urandom_range(0, 5));
    end

    // All-negative data: ReLU clamps, otherwise passes through.
    fill_const(-21'sd7);
    fin_pulse(1'b1);
    wait_cycles(3);
`ifdef POOL_RELU_EN
    chk("neg_px0", 32'(unsigned'(pool_a)), 32'h0);
`else
    chk("neg_px0", 32'(unsigned'(pool_a)), 32'h1ffff9);
`endif
    wait_cycles(4);
    do_reset(3);
    wait_cycles(2);
    fill_ramp();
    fin_pulse(1'b1);
    wait_cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
